// File: rtl/hw_module_perf_monitor_if.sv
// rtl/hw_module_perf_monitor_if.sv - ap_ctrl tap and statistics read bus for the perf monitor
interface hw_module_perf_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_ready;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;
    logic              rd_en;
    logic [3:0]        rd_ch;
    logic [2:0]        rd_reg;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue,
        output rd_en, rd_ch, rd_reg,
        input  rd_data, rd_valid
    );

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue,
        input  rd_en, rd_ch, rd_reg,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/hw_module_perf_monitor.sv
// rtl/hw_module_perf_monitor.sv - per-channel ap_ctrl handshake statistics with registered read port
module hw_module_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_clear,
    hw_module_perf_monitor_if.slave mon
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_ALL = {CNT_W{1'b1}};

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + C_ONE;
    endfunction

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;

    logic [1:0]        r_state      [NUM_CH];
    logic [CNT_W-1:0]  r_lat        [NUM_CH];
    logic [CNT_W-1:0]  r_ivl        [NUM_CH];
    logic [NUM_CH-1:0] r_ready_seen;

    logic [CNT_W-1:0]  r_txn        [NUM_CH];
    logic [CNT_W-1:0]  r_last_lat   [NUM_CH];
    logic [CNT_W-1:0]  r_min_lat    [NUM_CH];
    logic [CNT_W-1:0]  r_max_lat    [NUM_CH];
    logic [CNT_W-1:0]  r_last_ivl   [NUM_CH];
    logic [CNT_W-1:0]  r_stall      [NUM_CH];
    logic [CNT_W-1:0]  r_ovl        [NUM_CH];
    logic [NUM_CH-1:0] r_min_valid;
    logic [NUM_CH-1:0] r_ivl_valid;

    logic [NUM_CH-1:0] w_start;
    logic [NUM_CH-1:0] w_done;
    logic [NUM_CH-1:0] w_stall;
    logic [NUM_CH-1:0] w_ovl;
    logic [CNT_W-1:0]  w_lat_done   [NUM_CH];
    logic [CNT_W-1:0]  w_rd_mux;

    logic [CNT_W-1:0]  r_rd_data;
    logic              r_rd_valid;

    // Reset asserts asynchronously and releases two clocks later, in step with the clock.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Per-channel event decode: start, completion, stall cycle, overlapped start and latency at done.
    always_comb begin
        w_start = '0;
        w_done  = '0;
        w_stall = '0;
        w_ovl   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_start[c]    = (r_state[c] == S_IDLE) && mon.ap_start[c];
            w_done[c]     = mon.ap_done[c] && (w_start[c] || (r_state[c] == S_BUSY));
            w_lat_done[c] = w_start[c] ? C_ONE : f_sat_inc(r_lat[c]);
            w_stall[c]    = (r_state[c] == S_WAIT);
            w_ovl[c]      = ((r_state[c] == S_BUSY) || (r_state[c] == S_WAIT)) &&
                            r_ready_seen[c] && mon.ap_start[c] && mon.ap_ready[c];
        end
    end

    // Handshake FSMs and running counters; these ignore enable and clear so in-flight work is tracked.
    always_ff @(posedge i_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ready_seen <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= S_IDLE;
                r_lat[c]   <= '0;
                r_ivl[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_ivl[c] <= w_start[c] ? '0 : f_sat_inc(r_ivl[c]);
                case (r_state[c])
                    S_IDLE: begin
                        if (mon.ap_start[c]) begin
                            r_lat[c]        <= C_ONE;
                            r_ready_seen[c] <= mon.ap_ready[c];
                            if (mon.ap_done[c])
                                r_state[c] <= mon.ap_continue[c] ? S_IDLE : S_WAIT;
                            else
                                r_state[c] <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        r_lat[c] <= f_sat_inc(r_lat[c]);
                        if (mon.ap_ready[c])
                            r_ready_seen[c] <= 1'b1;
                        if (mon.ap_done[c])
                            r_state[c] <= mon.ap_continue[c] ? S_IDLE : S_WAIT;
                    end
                    S_WAIT: begin
                        if (mon.ap_continue[c])
                            r_state[c] <= S_IDLE;
                    end
                    default: r_state[c] <= S_IDLE;
                endcase
            end
        end
    end

    // Statistic registers: clear has priority over any same-cycle event, enable gates every update.
    always_ff @(posedge i_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_min_valid <= '0;
            r_ivl_valid <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_txn[c]      <= '0;
                r_last_lat[c] <= '0;
                r_min_lat[c]  <= C_ALL;
                r_max_lat[c]  <= '0;
                r_last_ivl[c] <= '0;
                r_stall[c]    <= '0;
                r_ovl[c]      <= '0;
            end
        end else if (i_clear) begin
            r_min_valid <= '0;
            r_ivl_valid <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_txn[c]      <= '0;
                r_last_lat[c] <= '0;
                r_min_lat[c]  <= C_ALL;
                r_max_lat[c]  <= '0;
                r_last_ivl[c] <= '0;
                r_stall[c]    <= '0;
                r_ovl[c]      <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_start[c])
                    r_ivl_valid[c] <= 1'b1;
                if (i_enable) begin
                    if (w_done[c]) begin
                        r_txn[c]       <= f_sat_inc(r_txn[c]);
                        r_last_lat[c]  <= w_lat_done[c];
                        r_min_valid[c] <= 1'b1;
                        if (w_lat_done[c] < r_min_lat[c]) r_min_lat[c] <= w_lat_done[c];
                        if (w_lat_done[c] > r_max_lat[c]) r_max_lat[c] <= w_lat_done[c];
                    end
                    if (w_start[c] && r_ivl_valid[c])
                        r_last_ivl[c] <= f_sat_inc(r_ivl[c]);
                    if (w_stall[c])
                        r_stall[c] <= f_sat_inc(r_stall[c]);
                    if (w_ovl[c])
                        r_ovl[c] <= f_sat_inc(r_ovl[c]);
                end
            end
        end
    end

    // Read select; channels beyond NUM_CH match nothing and read as zero.
    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mon.rd_ch == 4'(c)) begin
                case (mon.rd_reg)
                    3'd0:    w_rd_mux = r_txn[c];
                    3'd1:    w_rd_mux = r_last_lat[c];
                    3'd2:    w_rd_mux = r_min_lat[c];
                    3'd3:    w_rd_mux = r_max_lat[c];
                    3'd4:    w_rd_mux = r_last_ivl[c];
                    3'd5:    w_rd_mux = r_stall[c];
                    3'd6:    w_rd_mux = r_ovl[c];
                    default: w_rd_mux = {{(CNT_W-3){1'b0}}, r_min_valid[c], r_state[c]};
                endcase
            end
        end
    end

    // Registered read port: data captured from the request cycle, valid pulses one cycle later.
    always_ff @(posedge i_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= mon.rd_en;
            if (mon.rd_en)
                r_rd_data <= w_rd_mux;
        end
    end

    assign mon.rd_data  = r_rd_data;
    assign mon.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_hw_module_perf_monitor.sv
// tb/tb_hw_module_perf_monitor.sv - scoreboard bench for hw_module_perf_monitor
module tb_hw_module_perf_monitor;
    logic clk;
    logic rst_n;
    logic enable_a, clear_a, enable_b, clear_b;

    int n_checks;
    int n_fail;

    logic [31:0] qa_val[$];
    string       qa_tag[$];
    logic [31:0] qb_val[$];
    string       qb_tag[$];

    hw_module_perf_monitor_if #(.NUM_CH(4), .CNT_W(32)) ifa ();
    hw_module_perf_monitor_if #(.NUM_CH(4), .CNT_W(8))  ifb ();

    hw_module_perf_monitor #(.NUM_CH(4), .CNT_W(32)) u_dut_a (
        .i_clock (clk),
        .i_reset (rst_n),
        .i_enable(enable_a),
        .i_clear (clear_a),
        .mon     (ifa)
    );

    hw_module_perf_monitor #(.NUM_CH(4), .CNT_W(8)) u_dut_b (
        .i_clock (clk),
        .i_reset (rst_n),
        .i_enable(enable_b),
        .i_clear (clear_b),
        .mon     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_a(input logic [3:0] ch, input logic [2:0] rg, input logic [31:0] exp, input string tag);
        ifa.rd_en  = 1'b1;
        ifa.rd_ch  = ch;
        ifa.rd_reg = rg;
        qa_val.push_back(exp);
        qa_tag.push_back(tag);
        tick(1);
        ifa.rd_en = 1'b0;
    endtask

    task automatic rd_b(input logic [3:0] ch, input logic [2:0] rg, input logic [31:0] exp, input string tag);
        ifb.rd_en  = 1'b1;
        ifb.rd_ch  = ch;
        ifb.rd_reg = rg;
        qb_val.push_back(exp);
        qb_tag.push_back(tag);
        tick(1);
        ifb.rd_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ifa.rd_valid) begin
            if (qa_val.size() == 0) check_eq("a_unexpected_rd_valid", 32'd1, 32'd0);
            else check_eq(qa_tag.pop_front(), ifa.rd_data, qa_val.pop_front());
        end
        if (ifb.rd_valid) begin
            if (qb_val.size() == 0) check_eq("b_unexpected_rd_valid", 32'd1, 32'd0);
            else check_eq(qb_tag.pop_front(), {24'd0, ifb.rd_data}, qb_val.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        enable_a = 1'b1; clear_a = 1'b0;
        enable_b = 1'b1; clear_b = 1'b0;
        ifa.ap_start = '0; ifa.ap_ready = '0; ifa.ap_done = '0; ifa.ap_continue = '1;
        ifa.rd_en = 1'b0; ifa.rd_ch = '0; ifa.rd_reg = '0;
        ifb.ap_start = '0; ifb.ap_ready = '0; ifb.ap_done = '0; ifb.ap_continue = '1;
        ifb.rd_en = 1'b0; ifb.rd_ch = '0; ifb.rd_reg = '0;

        tick(3);
        check_eq("rst_rd_data_a", ifa.rd_data, 32'd0);
        check_eq("rst_rd_valid_a", {31'd0, ifa.rd_valid}, 32'd0);
        check_eq("rst_rd_data_b", {24'd0, ifb.rd_data}, 32'd0);
        rst_n = 1'b1;
        tick(3);
        rd_a(0, 3'd2, 32'hFFFF_FFFF, "rst_min");
        rd_a(0, 3'd0, 32'd0, "rst_txn");
        rd_a(0, 3'd7, 32'd0, "rst_status");
        rd_b(0, 3'd2, 32'h0000_00FF, "rst_min8");

        // Ch0: 5-cycle transaction
        ifa.ap_start[0] = 1'b1; tick(1);
        ifa.ap_start[0] = 1'b0; tick(3);
        ifa.ap_done[0]  = 1'b1; tick(1);
        ifa.ap_done[0]  = 1'b0;
        rd_a(0, 3'd0, 32'd1, "ch0_txn");
        rd_a(0, 3'd1, 32'd5, "ch0_last_lat");
        rd_a(0, 3'd2, 32'd5, "ch0_min_lat");
        rd_a(0, 3'd3, 32'd5, "ch0_max_lat");
        rd_a(0, 3'd7, 32'd4, "ch0_status");

        // Ch0 with enable low: nothing recorded
        enable_a = 1'b0;
        ifa.ap_start[0] = 1'b1; ifa.ap_done[0] = 1'b1; tick(1);
        ifa.ap_start[0] = 1'b0; ifa.ap_done[0] = 1'b0;
        enable_a = 1'b1;
        rd_a(0, 3'd0, 32'd1, "en0_txn");
        rd_a(0, 3'd1, 32'd5, "en0_last_lat");

        // Ch1: latency 1, then a start 20 cycles later
        ifa.ap_start[1] = 1'b1; ifa.ap_done[1] = 1'b1; tick(1);
        ifa.ap_start[1] = 1'b0; ifa.ap_done[1] = 1'b0;
        rd_a(1, 3'd4, 32'd0, "ch1_first_ivl");
        rd_a(1, 3'd1, 32'd1, "ch1_lat1");
        tick(17);
        ifa.ap_start[1] = 1'b1; ifa.ap_done[1] = 1'b1; tick(1);
        ifa.ap_start[1] = 1'b0; ifa.ap_done[1] = 1'b0;
        rd_a(1, 3'd4, 32'd20, "ch1_ivl");
        rd_a(1, 3'd0, 32'd2, "ch1_txn");

        // Ch2: continue held low for 7 cycles from done
        ifa.ap_start[2] = 1'b1; tick(1);
        ifa.ap_start[2] = 1'b0; tick(2);
        ifa.ap_done[2] = 1'b1; ifa.ap_continue[2] = 1'b0; tick(1);
        ifa.ap_done[2] = 1'b0;
        rd_a(2, 3'd7, 32'd6, "ch2_status_wait");
        tick(5);
        ifa.ap_continue[2] = 1'b1; tick(1);
        rd_a(2, 3'd5, 32'd7, "ch2_stall");
        rd_a(2, 3'd7, 32'd4, "ch2_status_idle");
        rd_a(2, 3'd1, 32'd4, "ch2_last_lat");

        // Ch3: ready at cycle 2, then an overlapped start in BUSY, 10-cycle transaction
        ifa.ap_start[3] = 1'b1; tick(1);
        ifa.ap_start[3] = 1'b0; ifa.ap_ready[3] = 1'b1; tick(1);
        ifa.ap_ready[3] = 1'b0; tick(2);
        ifa.ap_start[3] = 1'b1; ifa.ap_ready[3] = 1'b1; tick(1);
        ifa.ap_start[3] = 1'b0; ifa.ap_ready[3] = 1'b0; tick(4);
        ifa.ap_done[3] = 1'b1; tick(1);
        ifa.ap_done[3] = 1'b0;
        rd_a(3, 3'd6, 32'd1, "ch3_overlap");
        rd_a(3, 3'd0, 32'd1, "ch3_txn");
        rd_a(3, 3'd1, 32'd10, "ch3_last_lat");

        // Out-of-range channel selects
        rd_a(4'd15, 3'd0, 32'd0, "ch15_zero");
        rd_a(4'd4, 3'd1, 32'd0, "ch4_zero");

        // CNT_W=8: 300-cycle transaction saturates
        ifb.ap_start[0] = 1'b1; tick(1);
        ifb.ap_start[0] = 1'b0; tick(298);
        ifb.ap_done[0] = 1'b1; tick(1);
        ifb.ap_done[0] = 1'b0;
        rd_b(0, 3'd1, 32'd255, "b_sat_last_lat");
        rd_b(0, 3'd3, 32'd255, "b_sat_max_lat");

        // Clear mid-transaction with a simultaneous read
        ifb.ap_start[0] = 1'b1; tick(1);
        ifb.ap_start[0] = 1'b0; tick(9);
        clear_b = 1'b1;
        rd_b(0, 3'd0, 32'd1, "b_read_pre_clear");
        clear_b = 1'b0;
        ifb.ap_done[0] = 1'b1; tick(1);
        ifb.ap_done[0] = 1'b0;
        rd_b(0, 3'd0, 32'd1, "b_post_clear_txn");
        rd_b(0, 3'd1, 32'd12, "b_post_clear_lat");
        rd_b(0, 3'd2, 32'd12, "b_post_clear_min");

        // Clear and done in the same cycle: clear wins
        clear_b = 1'b1;
        ifb.ap_start[1] = 1'b1; ifb.ap_done[1] = 1'b1; tick(1);
        clear_b = 1'b0;
        ifb.ap_start[1] = 1'b0; ifb.ap_done[1] = 1'b0;
        rd_b(1, 3'd0, 32'd0, "b_clear_done_txn");
        rd_b(1, 3'd7, 32'd0, "b_clear_done_status");
        rd_b(0, 3'd0, 32'd0, "b_clear_ch0_txn");

        // Reset asserted mid-BUSY
        ifa.ap_start[0] = 1'b1;
        rd_a(3, 3'd0, 32'd1, "pre_rst_txn");
        ifa.ap_start[0] = 1'b0;
        tick(1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rd_data", ifa.rd_data, 32'd0);
        check_eq("midrst_rd_valid", {31'd0, ifa.rd_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        ifa.ap_done[0] = 1'b1; tick(1);
        ifa.ap_done[0] = 1'b0;
        rd_a(0, 3'd0, 32'd0, "postrst_txn");
        rd_a(0, 3'd7, 32'd0, "postrst_status");
        rd_a(0, 3'd2, 32'hFFFF_FFFF, "postrst_min");
        rd_a(3, 3'd6, 32'd0, "postrst_overlap");

        tick(3);
        check_eq("sb_drain_a", qa_val.size(), 32'd0);
        check_eq("sb_drain_b", qb_val.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hw_module_perf_monitor.md
# hw_module_perf_monitor

Synthesizable, parametrised performance monitor for HLS ap_ctrl block-level handshakes, the in-hardware counterpart of the simulation-only module status monitors. It observes NUM_CH independent ap_start/ap_ready/ap_done/ap_continue channels and keeps these per-channel statistics:
- transaction count
- latency: last, min and max
- start-to-start interval
- ap_continue stall cycles
- overlapped-start count

Statistics are read through a registered select port. The block sits beside the accelerator top, tapping control signals of the top and its sub-function instances.

## Interface
Parameters:
- NUM_CH, default 4: number of monitored handshake channels (1..16).
- CNT_W, default 32: width of every statistic register (8..32).

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- enable  in  1  1 = statistics update; 0 = statistics frozen, FSMs still track handshakes.
- clear  in  1  synchronous pulse; zeroes all statistics of all channels.
- ap_start  in  NUM_CH  per-channel ap_start.
- ap_ready  in  NUM_CH  per-channel ap_ready.
- ap_done  in  NUM_CH  per-channel ap_done.
- ap_continue  in  NUM_CH  per-channel ap_continue (tie 1 if absent).
- rd_en  in  1  read request.
- rd_ch  in  4  channel select.
- rd_reg  in  3  register select.
- rd_data  out  CNT_W  read data, valid when rd_valid = 1.
- rd_valid  out  1  one-cycle pulse, the cycle after rd_en.

## Operation
- Per-channel FSM states:
  - IDLE -> BUSY when ap_start = 1. This cycle is the start cycle. If ap_done = 1 in the same cycle, the transaction completes immediately, with latency 1.
  - BUSY -> IDLE on ap_done = 1 with ap_continue = 1.
  - BUSY -> WAIT_CONT on ap_done = 1 with ap_continue = 0.
  - WAIT_CONT -> IDLE on ap_continue = 1.
- Running latency counter:
  - Loads 1 on the start cycle and increments each cycle in BUSY.
  - On done it holds L = done cycle - start cycle + 1.
- Running interval counter:
  - Free-running since the last start.
  - On each start, last_interval takes value+1 and the counter restarts. The first start after reset or clear does not update last_interval.
- Overlap: ap_start & ap_ready seen in BUSY or WAIT_CONT after the channel's ready cycle of the current transaction increments overlap_count. No new latency measurement begins.
- Stall: each cycle in WAIT_CONT increments stall_cycles.
- On done with enable = 1:
  - txn_count += 1.
  - last_latency = L.
  - min_latency = min(min, L); max_latency = max(max, L).
- Counters saturate at 2^CNT_W-1 with no wrap. Running counters also saturate; a saturated L is recorded as all-ones.
- Register map (rd_reg):
  - 0 txn_count
  - 1 last_latency
  - 2 min_latency (all-ones = no sample)
  - 3 max_latency
  - 4 last_interval
  - 5 stall_cycles
  - 6 overlap_count
  - 7 status: bits[1:0] FSM state (0 IDLE, 1 BUSY, 2 WAIT_CONT), bit 2 = min valid, remaining bits 0.
- rd_ch >= NUM_CH returns 0.
- clear behaviour:
  - Zeroes all statistics, sets min_latency to all-ones, and invalidates the interval history.
  - FSM states and running latency counters are preserved, so an in-flight transaction is recorded after clear.
- enable = 0: no statistic register changes; the FSM and running counters continue.

## Timing
- Reset (reset = 0, asynchronous):
  - All FSMs go to IDLE.
  - All statistics 0, except min_latency = all-ones.
  - rd_data = 0, rd_valid = 0.
  - Reset release is synchronized internally; the first observed edge is two cycles after deassertion.
- Statistic updates are visible in the cycle after the done / WAIT_CONT / start event.
- Read latency is 1: rd_data and rd_valid are registered from the rd_en cycle's values.
- clear and rd_en in the same cycle: the read returns pre-clear values.
- clear and done in the same cycle: clear wins; the transaction is not counted.
- Reset asserted mid-transaction: the transaction is discarded with no partial record.

## Test plan
- Ch0: start at cycle 10, done at cycle 14, continue = 1 -> txn_count = 1, last/min/max_latency = 5, status = IDLE.
- Ch1: start and done in the same cycle, continue = 1 -> latency 1. Then start 20 cycles later -> last_interval = 20, txn_count = 2.
- Ch2: done with continue = 0 held 7 cycles -> status = WAIT_CONT during hold, stall_cycles = 7, then IDLE.
- Ch3: ready at cycle 2 of a 10-cycle transaction, then a second ap_start & ap_ready in BUSY -> overlap_count = 1, txn_count = 1 after done.
- CNT_W = 8, 300-cycle transaction -> last_latency = 255 (saturated). Then clear mid-transaction plus a simultaneous read -> read returns the old value; the next done records with txn_count = 1.
- Read rd_ch = 15 with NUM_CH = 4 -> rd_data = 0, rd_valid pulse. Assert reset mid-BUSY -> all outputs at reset values.
